// File: rtl/tm_model_loader.sv
// Byte-serial model loader for the Tsetlin Machine inference core: assembles
// exclusion/feature registers, commits atomically, returns the sampled class.
// Build option: define TM_LOADER_CHECKSUM_EN for the 7-byte packet with XOR checksum.
module tm_model_loader #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned INFER_LAT  = 2,
  parameter logic [31:0] RESET_EX   = 32'hC9C6_5C13,
  parameter logic [1:0]  RESET_FEAT = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] ex_bus,
  output logic [1:0]  features,
  output logic        model_valid,
  input  logic [1:0]  class_in,
  output logic [1:0]  result_class,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        pkt_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BODY   = 3'd1;
`ifdef TM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd2;
`endif
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]  state;
  logic [2:0]  idx;
  logic [31:0] stage_ex;
  logic [31:0] cnt;
  logic        accept;

`ifdef TM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  logic [1:0]  stage_feat;
`endif

  // s_ready depends on state only, never on s_valid
  always_comb begin
    s_ready = (state == S_IDLE) || (state == S_BODY);
`ifdef TM_LOADER_CHECKSUM_EN
    if (state == S_CHECK) s_ready = 1'b1;
`endif
  end

  assign accept       = s_valid && s_ready;
  assign result_valid = (state == S_RESULT);

`ifndef TM_LOADER_CHECKSUM_EN
  assign pkt_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      stage_ex     <= '0;
      cnt          <= '0;
      ex_bus       <= RESET_EX;
      features     <= RESET_FEAT;
      model_valid  <= 1'b0;
      result_class <= 2'b00;
`ifdef TM_LOADER_CHECKSUM_EN
      csum         <= '0;
      stage_feat   <= '0;
      pkt_err      <= 1'b0;
`endif
    end else begin
      model_valid <= 1'b0;
`ifdef TM_LOADER_CHECKSUM_EN
      pkt_err     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept && (s_data == HEADER)) begin
            state <= S_BODY;
            idx   <= '0;
`ifdef TM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end

        S_BODY: begin
          if (accept) begin
`ifdef TM_LOADER_CHECKSUM_EN
            csum <= csum ^ s_data;
`endif
            if (idx == 3'd4) begin
`ifdef TM_LOADER_CHECKSUM_EN
              stage_feat <= s_data[1:0];
              state      <= S_CHECK;
`else
              ex_bus      <= stage_ex;
              features    <= s_data[1:0];
              model_valid <= 1'b1;
              cnt         <= '0;
              state       <= S_WAIT;
`endif
            end else begin
              // B1 ends up in the top byte after four shifts (ex1 at MSB nibble)
              stage_ex <= {stage_ex[23:0], s_data};
              idx      <= idx + 3'd1;
            end
          end
        end

`ifdef TM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            if (s_data == csum) begin
              ex_bus      <= stage_ex;
              features    <= stage_feat;
              model_valid <= 1'b1;
              cnt         <= '0;
              state       <= S_WAIT;
            end else begin
              pkt_err <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end
`endif

        S_WAIT: begin
          if (cnt == INFER_LAT - 1) begin
            result_class <= class_in;
            state        <= S_RESULT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_RESULT: begin
          if (result_ready) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_model_loader.sv
// Scoreboard bench for tm_model_loader: stimulus pushes expected commits,
// results and checksum errors; a negedge monitor pops and compares them.
module tb_tm_model_loader;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] ex_bus;
  logic [1:0]  features;
  logic        model_valid;
  logic [1:0]  class_in = '0;
  logic [1:0]  result_class;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        pkt_err;

  tm_model_loader #(
    .HEADER    (8'hA5),
    .INFER_LAT (LAT),
    .RESET_EX  (32'hC9C6_5C13),
    .RESET_FEAT(2'b11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ex_bus      (ex_bus),
    .features    (features),
    .model_valid (model_valid),
    .class_in    (class_in),
    .result_class(result_class),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .pkt_err     (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ex; logic [1:0] feat; int t; } model_t;
  typedef struct { logic [1:0] cls; int t; } result_t;

  model_t  mq[$];
  result_t rq[$];
  int      eq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_t = 0;
  int first_t = 0;
  int hs_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor
  logic rv_prev = 1'b0;
  bit   hs_pending = 1'b0;
  int   rise = 0;
  always @(negedge clk) begin
    model_t  m;
    result_t r;
    int      te;
    if (rst) begin
      rv_prev    = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hs_pending) begin
        chk("post_hs_result_valid", {31'b0, result_valid}, 32'd0);
        chk("post_hs_s_ready", {31'b0, s_ready}, 32'd1);
        hs_pending = 1'b0;
      end
      if (model_valid) begin
        if (mq.size() == 0) flag_fail("unexpected_model_valid");
        else begin
          m = mq.pop_front();
          chk("commit_ex_bus", ex_bus, m.ex);
          chk("commit_features", {30'b0, features}, {30'b0, m.feat});
          chk("commit_cycle", cyc, m.t + 1);
        end
      end
      if (pkt_err) begin
        if (eq.size() == 0) flag_fail("unexpected_pkt_err");
        else begin
          te = eq.pop_front();
          chk("pkt_err_cycle", cyc, te + 1);
        end
      end
      if (result_valid && !rv_prev) rise = cyc;
      if (result_valid && result_ready) begin
        if (rq.size() == 0) flag_fail("unexpected_result");
        else begin
          r = rq.pop_front();
          chk("result_class", {30'b0, result_class}, {30'b0, r.cls});
          chk("result_rise_cycle", rise, r.t + LAT + 1);
        end
        hs_pending = 1'b1;
        hs_seen++;
      end
      rv_prev = result_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      flag_fail("byte_accept_timeout");
    end
    last_t = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] ex, input logic [7:0] b5, input logic [7:0] ck,
                          input logic [1:0] cls, input bit good, input bit gaps);
    logic [31:0] sh;
    model_t  m;
    result_t r;
    sh = ex;
    class_in = cls;
    send_byte(8'hA5);
    first_t = last_t;
    for (int i = 0; i < 4; i++) begin
      send_byte(sh[31:24]);
      sh = {sh[23:0], 8'h00};
      if (gaps && (i == 0 || i == 2)) begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
    send_byte(b5);
`ifdef TM_LOADER_CHECKSUM_EN
    send_byte(ck);
`endif
    if (good) begin
      m.ex = ex; m.feat = b5[1:0]; m.t = last_t;
      mq.push_back(m);
      r.cls = cls; r.t = last_t;
      rq.push_back(r);
    end else begin
      eq.push_back(last_t);
    end
  endtask

  task automatic wait_result();
    int n = 0;
    int h0 = hs_seen;
    while (hs_seen == h0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (hs_seen == h0) flag_fail("result_timeout");
    #1;
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_ex_bus", ex_bus, 32'hC9C65C13);
    chk("rst_features", {30'b0, features}, 32'd3);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_model_valid", {31'b0, model_valid}, 32'd0);
    chk("rst_result_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_pkt_err", {31'b0, pkt_err}, 32'd0);
    chk("rst_result_class", {30'b0, result_class}, 32'd0);
  endtask

  initial begin
    int bad_t;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();
    @(posedge clk);
    #1;

    // Good packet, class 01, consumer always ready
    send_pkt(32'h12345678, 8'h02, 8'h0A, 2'b01, 1'b1, 1'b0);
    wait_result();
    chk("hold_ex_bus", ex_bus, 32'h12345678);
    chk("hold_features", {30'b0, features}, 32'd2);

`ifdef TM_LOADER_CHECKSUM_EN
    // Bad checksum, then a header on the very next cycle
    send_pkt(32'h12345678, 8'h02, 8'h0B, 2'b01, 1'b0, 1'b0);
    bad_t = last_t;
    send_pkt(32'hCAFEF00D, 8'h01, 8'hC8, 2'b00, 1'b1, 1'b0);
    chk("b2b_header_cycle", first_t, bad_t + 1);
    wait_result();
`else
    send_pkt(32'hCAFEF00D, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
    wait_result();
`endif

    // Garbage before header; B5 upper bits ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    send_pkt(32'hDEADBEEF, 8'hFD, 8'hDF, 2'b10, 1'b1, 1'b0);
    wait_result();

    // Gapped body, consumer back-pressure for 10 cycles
    result_ready = 1'b0;
    send_pkt(32'h11223344, 8'h03, 8'h47, 2'b11, 1'b1, 1'b1);
    n = 0;
    while (!result_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    s_data  = 8'hA5;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_s_ready", {31'b0, s_ready}, 32'd0);
      chk("stall_result_valid", {31'b0, result_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    result_ready = 1'b1;
    wait_result();

    // Reset mid-packet
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();
    @(posedge clk);
    #1;
    send_pkt(32'h12345678, 8'h02, 8'h0A, 2'b01, 1'b1, 1'b0);
    wait_result();

    repeat (5) @(posedge clk);
    chk("model_queue_empty", mq.size(), 32'd0);
    chk("result_queue_empty", rq.size(), 32'd0);
    chk("err_queue_empty", eq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tm_model_loader.md
# tm_model_loader

Stream-side loader for the Tsetlin Machine inference core. Receives a byte-serial model packet on a valid/ready interface and assembles the eight 4-bit clause exclusion registers and the 2-bit feature vector. Commits them atomically to the inference core's inputs, then captures the core's class output after a fixed latency. Returns the class on a valid/ready result interface. It is the writer and host-facing end for the registers the inference core consumes.

## Interface
Parameters:
- HEADER, 8'hA5, packet start byte
- INFER_LAT, 2, cycles (≥1) the new model is applied before class_in is sampled
- RESET_EX, 32'hC9C6_5C13, exclusion bus value after reset (ex1 in [31:28] … ex8 in [3:0])
- RESET_FEAT, 2'b11, feature value after reset

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- s_data  in  8  packet byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts byte this cycle
- ex_bus  out  32  exclusion registers to inference core, ex1 at MSB nibble
- features  out  2  feature vector to inference core
- model_valid  out  1  one-cycle pulse on commit
- class_in  in  2  class output of inference core
- result_class  out  2  captured class
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- pkt_err  out  1  one-cycle pulse on checksum failure

## Operation
- Packet: HEADER, B1..B4 (high nibble = ex(2k−1), low nibble = ex(2k)), B5 (features = B5[1:0], B5[7:2] ignored), CK = B1^B2^B3^B4^B5.
- States: IDLE, BODY, CHECK, WAIT, RESULT.
- IDLE: s_ready=1. Accepted HEADER → BODY. Any other byte is dropped silently.
- BODY: s_ready=1. B1..B5 go to staging registers, with a running XOR. After B5 → CHECK.
- CHECK: s_ready=1. On CK match: ex_bus/features load from staging, model_valid pulses, → WAIT. On mismatch: outputs unchanged, pkt_err pulses, → IDLE.
- WAIT: s_ready=0. Counts INFER_LAT cycles, then samples class_in into result_class → RESULT.
- RESULT: s_ready=0, result_valid=1 until result_valid&&result_ready, then → IDLE.
- A byte is transferred only when s_valid&&s_ready. s_valid low inside a packet stalls; there is no timeout.
- A HEADER byte value inside BODY/CHECK is treated as data; there is no resync.

## Timing
- Reset values: ex_bus=RESET_EX, features=RESET_FEAT, model_valid=0, pkt_err=0, result_valid=0, result_class=2'b00, state IDLE (s_ready=1 in the first cycle after reset).
- s_ready is decoded from state with no combinational path from s_valid.
- Final byte accepted in cycle T:
  - ex_bus/features hold the new value from T+1.
  - model_valid=1 in T+1 only.
  - class_in is sampled at the edge ending cycle T+INFER_LAT.
  - result_valid=1 from T+INFER_LAT+1.
- On a bad checksum, pkt_err=1 in T+1 only. s_ready stays 1, so a back-to-back HEADER in T+1 is accepted.
- Result handshake accepted in cycle R: result_valid=0 and s_ready=1 in R+1.
- rst mid-operation (any state): staging and counters clear, outputs return to reset values, and any pending result is lost.

## Configuration
- TM_LOADER_CHECKSUM_EN defined: 7-byte packet as above, CHECK state present, pkt_err functional.
- Not defined: 6-byte packet (no CK). The byte after B5 is not expected; commit happens on acceptance of B5, with identical T-relative timing. CHECK state and XOR logic are absent, and pkt_err is tied 0.

## Test plan
- Reset: hold rst 3 cycles → ex_bus=0xC9C65C13, features=2'b11, s_ready=1, model_valid/result_valid/pkt_err=0.
- Good packet A5 12 34 56 78 02 0A, class_in=2'b01 held, result_ready=1 → ex_bus=0x12345678, features=2'b10, one model_valid pulse, result_valid for one cycle at T+3 with result_class=2'b01.
- Bad checksum: same packet with CK=0B → pkt_err one pulse, ex_bus stays at its previous value, no model_valid/result_valid, next HEADER accepted immediately.
- Garbage 00 FF 3C, then good packet → garbage dropped, packet commits normally.
- result_ready low for 10 cycles after result → result_valid held, s_ready=0 and no bytes consumed. After result_ready=1, s_ready=1 on the next cycle. Also exercise s_valid gaps mid-body.
- rst asserted after A5 12 34 → reset values restored. A subsequent full packet commits correctly. Rerun the suite with TM_LOADER_CHECKSUM_EN undefined using 6-byte packets.
